// File: rtl/t08_lsu_pkg.sv
// Shared types and encodings for the t08 load/store and fetch unit.
package t08_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_ILLEGAL  = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

endpackage

// File: rtl/t08_lsu_lane.sv
// Byte-lane logic: store strobes/replication, load lane extraction with
// extension, and the legality/alignment checks for a data access.
module t08_lsu_lane
    import t08_lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ext,
    output logic        illegal,
    output logic        misalign
);

    logic        load_ok;
    logic        store_ok;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        load_ok   = func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        store_ok  = func3 inside {F3_B, F3_H, F3_W};
        illegal   = (rd & wr) | (rd & ~load_ok) | (wr & ~store_ok);
        misalign  = 1'b0;
        be        = 4'hF;
        wdata_rep = wdata;
        // func3[1:0] is the access size for every legal encoding
        case (func3[1:0])
            2'd0: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'd1: begin
                misalign  = off[0];
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: misalign = (off != 2'b00);
        endcase
    end

    always_comb begin
        case (off)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (func3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ext = {24'd0, byte_sel};
            F3_HU:   ext = {16'd0, half_sel};
            default: ext = bus_rdata;
        endcase
    end

endmodule

// File: rtl/t08_lsu_arbiter.sv
// Load/store and fetch arbiter for the single shared memory bus: data
// accesses win over fetch, with fault detection and a bus-wait timeout.
module t08_lsu_arbiter
    import t08_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              dreq_read,
    input  logic              dreq_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       wdata,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    output logic [31:0]       rdata,
    output logic              data_done,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic              freeze,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              data_done_q, data_done_d;
    logic [31:0]       instruction_q, instruction_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;

    logic              data_req;
    logic [2:0]        lane_f3;
    logic [1:0]        lane_off;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_ext;
    logic              lane_illegal;
    logic              lane_misalign;

    // While a transfer is in flight the lane decodes the latched access.
    assign lane_f3  = (state_q == DATA) ? f3_q  : func3;
    assign lane_off = (state_q == DATA) ? off_q : daddr[1:0];

    t08_lsu_lane u_lane (
        .func3     (lane_f3),
        .off       (lane_off),
        .rd        (dreq_read),
        .wr        (dreq_write),
        .wdata     (wdata),
        .bus_rdata (bus_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .ext       (lane_ext),
        .illegal   (lane_illegal),
        .misalign  (lane_misalign)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        f3_d          = f3_q;
        off_d         = off_q;
        rdata_d       = rdata_q;
        instruction_d = instruction_q;
        fault_code_d  = fault_code_q;
        data_done_d   = 1'b0;
        instr_valid_d = 1'b0;
        fault_d       = 1'b0;
        // A request still held in the data_done cycle is the finished one.
        data_req      = (dreq_read | dreq_write) & ~data_done_q;

        unique case (state_q)
            IDLE: begin
                if (data_req) begin
                    if (lane_illegal) begin
                        fault_d      = 1'b1;
                        fault_code_d = FLT_ILLEGAL;
                        data_done_d  = 1'b1;
                    end else if (lane_misalign) begin
                        fault_d      = 1'b1;
                        fault_code_d = FLT_MISALIGN;
                        data_done_d  = 1'b1;
                    end else begin
                        state_d     = DATA;
                        cnt_d       = '0;
                        bus_we_d    = dreq_write;
                        bus_addr_d  = {daddr[ADDR_W-1:2], 2'b00};
                        bus_be_d    = lane_be;
                        bus_wdata_d = lane_wdata;
                        f3_d        = func3;
                        off_d       = daddr[1:0];
                    end
                end else if (fetch_en) begin
                    if (pc[1:0] != 2'b00) begin
                        fault_d      = 1'b1;
                        fault_code_d = FLT_MISALIGN;
                    end else begin
                        state_d     = FETCH;
                        cnt_d       = '0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = {pc[ADDR_W-1:2], 2'b00};
                        bus_be_d    = 4'hF;
                        bus_wdata_d = '0;
                    end
                end
            end
            DATA, FETCH: begin
                if (bus_ack || (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                    data_done_d = (state_q == DATA);
                end
                if (bus_ack) begin
                    if (state_q == DATA) begin
                        if (!bus_we_q) rdata_d = lane_ext;
                    end else begin
                        instruction_d = bus_rdata;
                        instr_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    fault_d      = 1'b1;
                    fault_code_d = FLT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            rdata_q       <= '0;
            data_done_q   <= 1'b0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            rdata_q       <= rdata_d;
            data_done_q   <= data_done_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign bus_req     = (state_q != IDLE);
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata       = rdata_q;
    assign data_done   = data_done_q;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign freeze      = ((state_q != IDLE) | dreq_read | dreq_write) & ~data_done_q;

endmodule

// File: tb/tb_t08_lsu_arbiter.sv
// Randomised bench for t08_lsu_arbiter: a CPU-like driver and bus responder,
// checked against a transaction-level model of the access rules.
module tb_t08_lsu_arbiter;
    import t08_lsu_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TO     = 64;

    logic              clk = 1'b0;
    logic              nrst;
    logic              dreq_read, dreq_write, fetch_en, bus_ack;
    logic [2:0]        func3;
    logic [ADDR_W-1:0] daddr, pc;
    logic [31:0]       wdata, bus_rdata;
    logic              bus_req, bus_we, data_done, instr_valid, freeze, fault;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata, rdata, instruction;
    logic [3:0]        bus_be;
    logic [1:0]        fault_code;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_rdata, exp_instr;
    logic [1:0]  exp_code;

    t08_lsu_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nrst(nrst), .dreq_read(dreq_read), .dreq_write(dreq_write),
        .func3(func3), .daddr(daddr), .wdata(wdata), .fetch_en(fetch_en), .pc(pc),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .rdata(rdata),
        .data_done(data_done), .instruction(instruction), .instr_valid(instr_valid),
        .freeze(freeze), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one data access, from the access rules alone.
    function automatic void model_data(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       input logic [31:0] rw, output logic [1:0] code,
                                       output logic [3:0] be, output logic [31:0] wbus,
                                       output logic [31:0] ext);
        int nb, off;
        logic [31:0] v;
        nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        if (rd && wr) code = 2'd2;
        else if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) code = 2'd2;
        else if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) code = 2'd2;
        else if ((off % nb) != 0) code = 2'd1;
        else code = 2'd0;
        be = 4'(((1 << nb) - 1) << off);
        case (nb)
            1:       wbus = {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       wbus = {16'd0, wd[15:0]} * 32'h0001_0001;
            default: wbus = wd;
        endcase
        v = rw >> (8 * off);
        if (nb == 1) begin
            ext = v & 32'hFF;
            if (f3 == 3'd0 && v[7]) ext = ext | 32'hFFFF_FF00;
        end else if (nb == 2) begin
            ext = v & 32'hFFFF;
            if (f3 == 3'd1 && v[15]) ext = ext | 32'hFFFF_0000;
        end else begin
            ext = rw;
        end
    endfunction

    task automatic do_data(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int d);
        logic [1:0]  code;
        logic [3:0]  be;
        logic [31:0] wbus, ext;
        int exp_end, exp_nreq, cyc, nreq;
        bit done;
        model_data(rd, wr, f3, a, wd, rw, code, be, wbus, ext);
        if (code != 2'd0) begin exp_end = 1; exp_nreq = 0; end
        else if (d >= TO) begin exp_end = TO + 1; exp_nreq = TO; code = 2'd3; end
        else begin exp_end = d + 2; exp_nreq = d + 1; end
        @(negedge clk);
        dreq_read = rd; dreq_write = wr; func3 = f3; daddr = a; wdata = wd;
        cyc = 0; nreq = 0; done = 1'b0;
        while (!done && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0;
            check_eq("d_freeze", 32'(freeze), 32'(cyc < exp_end));
            if (bus_req) begin
                check_eq("d_bus_addr", bus_addr, {a[31:2], 2'b00});
                check_eq("d_bus_we", 32'(bus_we), 32'(wr));
                check_eq("d_bus_be", 32'(bus_be), 32'(be));
                if (wr) check_eq("d_bus_wdata", bus_wdata, wbus);
                if (nreq == d) begin bus_ack = 1'b1; bus_rdata = rw; end
                else bus_rdata = $urandom;
                nreq++;
            end
            if (data_done) begin
                done = 1'b1;
                dreq_read = 1'b0; dreq_write = 1'b0;
                if (code != 2'd0) exp_code = code;
                else if (rd) exp_rdata = ext;
                check_eq("d_done_cycle", cyc, exp_end);
                check_eq("d_nreq", nreq, exp_nreq);
                check_eq("d_fault", 32'(fault), 32'(code != 2'd0));
                check_eq("d_fault_code", 32'(fault_code), 32'(exp_code));
                check_eq("d_rdata", rdata, exp_rdata);
                check_eq("d_instr", instruction, exp_instr);
                check_eq("d_iv", 32'(instr_valid), 32'd0);
            end
        end
        check_eq("d_done_seen", 32'(done), 32'd1);
        bus_ack = 1'b0; dreq_read = 1'b0; dreq_write = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] p, input logic [31:0] word, input int d);
        logic [1:0] code;
        int exp_end, exp_nreq, cyc, nreq;
        bit done;
        if (p[1:0] != 2'd0) begin code = 2'd1; exp_end = 1; exp_nreq = 0; end
        else if (d >= TO) begin code = 2'd3; exp_end = TO + 1; exp_nreq = TO; end
        else begin code = 2'd0; exp_end = d + 2; exp_nreq = d + 1; end
        @(negedge clk);
        fetch_en = 1'b1; pc = p;
        cyc = 0; nreq = 0; done = 1'b0;
        while (!done && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0;
            check_eq("f_freeze", 32'(freeze), 32'(cyc < exp_end));
            if (bus_req) begin
                check_eq("f_bus_addr", bus_addr, {p[31:2], 2'b00});
                check_eq("f_bus_we", 32'(bus_we), 32'd0);
                check_eq("f_bus_be", 32'(bus_be), 32'hF);
                if (nreq == d) begin bus_ack = 1'b1; bus_rdata = word; end
                else bus_rdata = $urandom;
                nreq++;
            end
            if (instr_valid || fault) begin
                done = 1'b1;
                fetch_en = 1'b0;
                if (code != 2'd0) exp_code = code;
                else exp_instr = word;
                check_eq("f_end_cycle", cyc, exp_end);
                check_eq("f_nreq", nreq, exp_nreq);
                check_eq("f_iv", 32'(instr_valid), 32'(code == 2'd0));
                check_eq("f_fault_code", 32'(fault_code), 32'(exp_code));
                check_eq("f_instr", instruction, exp_instr);
                check_eq("f_rdata", rdata, exp_rdata);
                check_eq("f_done", 32'(data_done), 32'd0);
            end
        end
        check_eq("f_end_seen", 32'(done), 32'd1);
        bus_ack = 1'b0; fetch_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"}, 32'(bus_req), 32'd0);
        check_eq({tag, "_we"}, 32'(bus_we), 32'd0);
        check_eq({tag, "_addr"}, bus_addr, 32'd0);
        check_eq({tag, "_be"}, 32'(bus_be), 32'd0);
        check_eq({tag, "_wdata"}, bus_wdata, 32'd0);
        check_eq({tag, "_rdata"}, rdata, 32'd0);
        check_eq({tag, "_done"}, 32'(data_done), 32'd0);
        check_eq({tag, "_instr"}, instruction, 32'd0);
        check_eq({tag, "_iv"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_freeze"}, 32'(freeze), 32'd0);
        check_eq({tag, "_fault"}, 32'(fault), 32'd0);
        check_eq({tag, "_code"}, 32'(fault_code), 32'd0);
    endtask

    initial begin
        logic [31:0] xfer_q[$];
        int done_at, iv_at, niv;
        logic prev_req;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] a, p;
        int r, d;

        nrst = 1'b0; dreq_read = 1'b0; dreq_write = 1'b0; fetch_en = 1'b0;
        func3 = '0; daddr = '0; wdata = '0; pc = '0; bus_rdata = '0; bus_ack = 1'b0;
        exp_rdata = '0; exp_instr = '0; exp_code = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        nrst = 1'b1;

        do_data(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h8012_3456, 0);
        check_eq("plan_lb", rdata, 32'hFFFF_FF80);
        do_data(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h8012_3456, 0);
        check_eq("plan_lbu", rdata, 32'h0000_0080);
        do_data(1'b0, 1'b1, F3_H, 32'h202, 32'h0000_BEEF, 32'h0, 0);
        do_data(1'b1, 1'b0, F3_W, 32'h006, 32'h0, 32'h1234_5678, 0);
        check_eq("plan_lw_misalign", 32'(fault_code), 32'd1);
        do_data(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h1234_5678, 0);
        check_eq("plan_f3_illegal", 32'(fault_code), 32'd2);
        do_data(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'hDEAD_0000, TO);
        check_eq("plan_timeout_code", 32'(fault_code), 32'd3);
        check_eq("plan_timeout_rdata", rdata, 32'h0000_0080);

        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_ack_req", 32'(bus_req), 32'd0);
            check_eq("idle_ack_done", 32'(data_done), 32'd0);
            check_eq("idle_ack_iv", 32'(instr_valid), 32'd0);
            check_eq("idle_ack_rdata", rdata, exp_rdata);
        end
        bus_ack = 1'b0;

        // data request and fetch raised together
        @(negedge clk);
        dreq_read = 1'b1; func3 = F3_W; daddr = 32'h80; fetch_en = 1'b1; pc = 32'h40;
        done_at = -1; iv_at = -1; niv = 0; prev_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                if (!prev_req) xfer_q.push_back(bus_addr);
                bus_ack = 1'b1;
                bus_rdata = (bus_addr == 32'h40) ? 32'h0050_0093 : 32'h1122_3344;
            end
            prev_req = bus_req;
            if (data_done) begin done_at = c; dreq_read = 1'b0; end
            if (instr_valid) begin iv_at = c; niv++; fetch_en = 1'b0; end
        end
        bus_ack = 1'b0; dreq_read = 1'b0; fetch_en = 1'b0;
        check_eq("both_nxfer", xfer_q.size(), 2);
        if (xfer_q.size() > 0) check_eq("both_first", xfer_q[0], 32'h80);
        if (xfer_q.size() > 1) check_eq("both_second", xfer_q[1], 32'h40);
        check_eq("both_done_at", done_at, 2);
        check_eq("both_iv_at", iv_at, 4);
        check_eq("both_niv", niv, 1);
        check_eq("both_instr", instruction, 32'h0050_0093);
        check_eq("both_rdata", rdata, 32'h1122_3344);
        exp_instr = 32'h0050_0093;
        exp_rdata = 32'h1122_3344;

        for (int i = 0; i < 120; i++) begin
            d = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                p = $urandom;
                if ($urandom_range(0, 4) != 0) p[1:0] = 2'd0;
                do_fetch(p, $urandom, d);
            end else begin
                r  = int'($urandom_range(0, 15));
                rd = (r < 8);
                wr = (r >= 8) || (r == 0);
                if ($urandom_range(0, 3) != 0) begin
                    if (rd && !wr) begin
                        r  = int'($urandom_range(0, 4));
                        f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
                    end else begin
                        f3 = 3'($urandom_range(0, 2));
                    end
                end else begin
                    f3 = 3'($urandom_range(0, 7));
                end
                a = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'd1) a[0] = 1'b0;
                    else if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
                end
                do_data(rd, wr, f3, a, $urandom, $urandom, d);
            end
        end

        // reset in the middle of a pending data transfer
        @(negedge clk);
        dreq_read = 1'b1; func3 = F3_W; daddr = 32'h500; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pre_req", 32'(bus_req), 32'd1);
        #2;
        nrst = 1'b0; dreq_read = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        nrst = 1'b1;
        exp_rdata = '0; exp_instr = '0; exp_code = '0;
        do_fetch(32'h44, 32'h00A0_0113, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/t08_lsu_arbiter.md
Name: t08_lsu_arbiter

Overview:
Parametrised load/store and fetch unit. It is the next generation of the team's single-port memory handler and sits between the t08 CPU core and the single shared memory/MMIO bus. It arbitrates data accesses against instruction fetch, and generates byte-lane strobes from func3 and the address. It sign- or zero-extends loads from the addressed lane, detects misaligned or illegal accesses, and aborts bus transfers that exceed a programmable timeout.

Parameters:
ADDR_W, 32, width of the address buses.
TIMEOUT_CYCLES, 64, number of bus-wait cycles without bus_ack before abort (>=2).
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
dreq_read  in  1  CPU load request, held until data_done
dreq_write  in  1  CPU store request, held until data_done
func3  in  3  RISC-V funct3 of the load/store
daddr  in  ADDR_W  data byte address
wdata  in  32  store data, LSB-aligned
fetch_en  in  1  CPU wants the next instruction
pc  in  ADDR_W  fetch address
bus_rdata  in  32  memory read data (valid with bus_ack)
bus_ack  in  1  memory completes the transfer this cycle
bus_req  out  1  transfer request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word address (byte address with [1:0] = 0)
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
rdata  out  32  extended load result
data_done  out  1  one-cycle pulse: data access finished (ok or fault)
instruction  out  32  last fetched instruction
instr_valid  out  1  one-cycle pulse: instruction updated
freeze  out  1  stall to the CPU
fault  out  1  one-cycle pulse on an error
fault_code  out  2  1 misaligned, 2 illegal op, 3 timeout; holds until the next fault

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; timeout counter 0. bus_req drops immediately with nrst.
- States:
  - IDLE: a data request has priority over fetch.
    - Request legal -> DATA.
    - Request illegal -> fault/data_done pulse next cycle, stay IDLE.
    - No data request and fetch_en: pc[1:0] == 0 -> FETCH; otherwise fault code 1 and instr_valid 0.
  - DATA: bus_req = 1; bus_we, bus_addr, bus_be and bus_wdata stay stable until bus_ack.
    - On bus_ack -> IDLE. rdata is latched for loads only; data_done pulses the next cycle.
  - FETCH: bus_req = 1, bus_we = 0, bus_be = 4'hF.
    - On bus_ack -> IDLE; instruction <= bus_rdata; instr_valid pulses the next cycle.
- Timeout: the counter clears on entry to DATA/FETCH and increments on each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: bus_req drops, -> IDLE, fault code 3.
  - A data timeout also pulses data_done; rdata and instruction stay unchanged.
- Legality:
  - Loads: func3 in {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU}.
  - Stores: func3 in {0 SB, 1 SH, 2 SW}.
  - Other func3, or dreq_read & dreq_write together -> code 2.
  - Half access with daddr[0] = 1, or word access with daddr[1:0] != 0 -> code 1.
  - No bus transfer is issued on any fault.
- Stores, with off = daddr[1:0]:
  - SB: bus_be = 4'b0001 << off; bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_be = 4'b0011 << off; bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_be = 4'hF; bus_wdata = wdata.
- Loads: select byte lane off (or halfword lane off[1]).
  - LB/LH: sign-extend from bit 7/15 of the selected lane, never from bus_rdata[31].
  - LBU/LHU: zero-extend. LW: pass through.
- Latency with a zero-wait bus (ack in the same cycle as req): request seen in cycle 0, bus_req in cycle 1, data_done/instr_valid in cycle 2.
- freeze = (state != IDLE) | dreq_read | dreq_write, except that freeze is 0 in the cycle data_done pulses.
  - The CPU must drop its request in that cycle. A request still high one cycle after data_done is treated as a new access.
- Simultaneous events:
  - A data request arriving during FETCH waits for the fetch to finish.
  - A fetch_en arriving during DATA is served afterwards.
  - bus_ack in IDLE is ignored.
- Fault does not alter instruction or rdata.

Decomposition:
- Package t08_lsu_pkg holds:
  - the state enum (IDLE, DATA, FETCH);
  - funct3 localparams (F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5);
  - fault-code localparams (FLT_MISALIGN = 1, FLT_ILLEGAL = 2, FLT_TIMEOUT = 3).
- Sub-module t08_lsu_lane, purely combinational, computes bus_be, bus_wdata, the extended rdata value and the legality/misalign flags from func3, off, wdata and bus_rdata.
- The top level holds the FSM, timeout counter and output registers.

Test Plan:
- LB at daddr 0x103, bus_rdata 0x80_12_34_56, ack in the same cycle -> bus_be 4'b1000 unused for the read, rdata 0xFFFF_FF80, data_done in cycle 2; LBU -> 0x0000_0080.
- SH at daddr 0x202, wdata 0x0000_BEEF -> bus_addr 0x200, bus_be 4'b1100, bus_wdata 0xBEEF_BEEF, bus_we 1.
- LW at daddr 0x006 -> no bus_req, fault code 1, data_done pulse. func3 = 3 load -> code 2.
- Load with ack withheld for TIMEOUT_CYCLES (64) -> bus_req drops after 64 cycles, fault code 3, rdata unchanged.
- fetch_en and dreq_read in the same IDLE cycle -> data transfer first, then fetch at pc 0x40. instruction = 0x00500093, instr_valid pulses once.
- nrst pulled low while in DATA with ack pending -> bus_req 0 immediately, all outputs 0; after release, a fresh fetch completes normally.
